seq_hex_calculator: RTL and testbench

- Parametrised, clocked successor to the combinational 4-bit adder/seven-segment block.
- Holds a WIDTH-bit accumulator and applies ADD, SUB, LOAD or a multi-cycle shift-add MUL with the SW operand on each ENTER strobe.
- Shows the accumulator in hex on WIDTH/4 active-low seven-segment digits.
- Sits directly between board switches/keys and the HEX displays.

---
 rtl/seq_hex_calculator.sv | 192 +++++++++++++++++++
 tb/tb_seq_hex_calculator.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_hex_calculator.sv
// ---------------------------------------------------------------------------
// seq_hex_calculator
//   Clocked accumulator calculator with a hex seven-segment readout.
//   On each ENTER strobe the accumulator is combined with the SW operand:
//   ADD, SUB and LOAD complete in one cycle. MUL is a WIDTH-cycle shift-add
//   sequence, and BUSY stays high while it runs.
//
//   Build option: define SATURATE_EN to clamp overflowing results.
//   ADD and MUL clamp to all ones, and SUB clamps to zero. CARRY is still
//   set. When SATURATE_EN is not defined, results wrap modulo 2^WIDTH.
//
// Parameters
//   WIDTH      operand / accumulator width; multiple of 4, >= 4
//
// Ports
//   CLOCK_50   in   1              system clock, rising edge
//   RESET      in   1              asynchronous active-high reset
//   SW         in   WIDTH          operand
//   OP         in   2              00 ADD, 01 SUB, 10 MUL, 11 LOAD
//   ENTER      in   1              single-cycle operation strobe
//   BUSY       out  1              multiply in progress
//   CARRY      out  1              carry/borrow/overflow of last operation
//   HEX        out  7*WIDTH/4      active-low gfedcba digits, digit 0 = LS nibble
// ---------------------------------------------------------------------------
module seq_hex_calculator #(
  parameter int WIDTH = 8
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET,
  input  logic [WIDTH-1:0]        SW,
  input  logic [1:0]              OP,
  input  logic                    ENTER,
  output logic                    BUSY,
  output logic                    CARRY,
  output logic [7*(WIDTH/4)-1:0]  HEX
);

  localparam int NUM_DIGITS = WIDTH / 4;
  localparam int CW         = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [WIDTH-1:0]     r_acc, w_acc_nxt;
  logic                 r_carry, w_carry_nxt;
  logic [2*WIDTH-1:0]   r_mcand_sh, w_mcand_nxt;
  logic [WIDTH-1:0]     r_mplier, w_mplier_nxt;
  logic [2*WIDTH-1:0]   r_prod, w_prod_nxt;
  logic [CW-1:0]        r_count, w_count_nxt;

  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_prod_step;
  logic [7*NUM_DIGITS-1:0] w_hex;

  function automatic logic [6:0] f_seg7(input logic [3:0] n);
    logic [6:0] seg;
    case (n)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // One extra bit captures the ADD carry-out and the SUB borrow.
  assign w_sum  = {1'b0, r_acc} + {1'b0, SW};
  assign w_diff = {1'b0, r_acc} - {1'b0, SW};

  // Shift-add step. The multiplier is consumed from its LSB, and the
  // multiplicand moves one place left for each step.
  assign w_prod_step = r_prod + (r_mplier[0] ? r_mcand_sh : '0);

  // State register
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and datapath next values
  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_carry_nxt  = r_carry;
    w_mcand_nxt  = r_mcand_sh;
    w_mplier_nxt = r_mplier;
    w_prod_nxt   = r_prod;
    w_count_nxt  = r_count;

    case (r_state)
      S_IDLE: begin
        if (ENTER) begin
          case (OP)
            2'b00: begin
              w_acc_nxt   = w_sum[WIDTH-1:0];
              w_carry_nxt = w_sum[WIDTH];
`ifdef SATURATE_EN
              if (w_sum[WIDTH]) w_acc_nxt = '1;
`endif
            end
            2'b01: begin
              w_acc_nxt   = w_diff[WIDTH-1:0];
              w_carry_nxt = w_diff[WIDTH];
`ifdef SATURATE_EN
              if (w_diff[WIDTH]) w_acc_nxt = '0;
`endif
            end
            2'b10: begin
              w_mcand_nxt  = {{WIDTH{1'b0}}, SW};
              w_mplier_nxt = r_acc;
              w_prod_nxt   = '0;
              w_count_nxt  = '0;
              w_state_nxt  = S_MUL;
            end
            default: begin
              w_acc_nxt   = SW;
              w_carry_nxt = 1'b0;
            end
          endcase
        end
      end

      S_MUL: begin
        w_prod_nxt   = w_prod_step;
        w_mcand_nxt  = {r_mcand_sh[2*WIDTH-2:0], 1'b0};
        w_mplier_nxt = {1'b0, r_mplier[WIDTH-1:1]};
        w_count_nxt  = r_count + CW'(1);
        // The final step writes the accumulator directly from the adder
        // output. This lets the result land on the same edge that leaves MUL.
        if (r_count == LAST_STEP) begin
          w_acc_nxt   = w_prod_step[WIDTH-1:0];
          w_carry_nxt = |w_prod_step[2*WIDTH-1:WIDTH];
`ifdef SATURATE_EN
          if (|w_prod_step[2*WIDTH-1:WIDTH]) w_acc_nxt = '1;
`endif
          w_state_nxt = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_acc      <= '0;
      r_carry    <= 1'b0;
      r_mcand_sh <= '0;
      r_mplier   <= '0;
      r_prod     <= '0;
      r_count    <= '0;
    end else begin
      r_acc      <= w_acc_nxt;
      r_carry    <= w_carry_nxt;
      r_mcand_sh <= w_mcand_nxt;
      r_mplier   <= w_mplier_nxt;
      r_prod     <= w_prod_nxt;
      r_count    <= w_count_nxt;
    end
  end

  // Display decode from the accumulator. There is no output register.
  always_comb begin
    w_hex = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      w_hex[7*i +: 7] = f_seg7(r_acc[4*i +: 4]);
    end
  end

  assign HEX   = w_hex;
  assign BUSY  = (r_state == S_MUL);
  assign CARRY = r_carry;

endmodule

// File: tb/tb_seq_hex_calculator.sv
// ---------------------------------------------------------------------------
// tb_seq_hex_calculator
//   Directed self-checking bench for seq_hex_calculator at WIDTH=8.
//   The expected results follow the SATURATE_EN setting of the build.
// ---------------------------------------------------------------------------
module tb_seq_hex_calculator;

  localparam int WIDTH = 8;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  logic              CLOCK_50;
  logic              RESET;
  logic [WIDTH-1:0]  SW;
  logic [1:0]        OP;
  logic              ENTER;
  logic              BUSY;
  logic              CARRY;
  logic [13:0]       HEX;

  int n_tests = 0;
  int n_fail  = 0;

  seq_hex_calculator #(.WIDTH(WIDTH)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .SW       (SW),
    .OP       (OP),
    .ENTER    (ENTER),
    .BUSY     (BUSY),
    .CARRY    (CARRY),
    .HEX      (HEX)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  // Reference segment table, 0..F, active-low gfedcba
  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[n];
  endfunction

  function automatic logic [13:0] hex_ref(input logic [7:0] v);
    return {seg_ref(v[7:4]), seg_ref(v[3:0])};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one operation for one rising edge; returns at the following negedge.
  task automatic do_op(input logic [1:0] op, input logic [7:0] sw);
    @(negedge CLOCK_50);
    OP = op; SW = sw; ENTER = 1'b1;
    @(negedge CLOCK_50);
    ENTER = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (BUSY && n < 40) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (BUSY) check({tag, "_timeout"}, 32'(BUSY), 32'd0);
  endtask

  logic [7:0] digit_vals [8];
  logic [7:0] exp_acc;
  int         busy_cycles;

  initial begin
    RESET = 1'b1; SW = '0; OP = '0; ENTER = 1'b0;
    #12;
    check("rst_hex",   32'(HEX),   32'(hex_ref(8'h00)));
    check("rst_busy",  32'(BUSY),  32'd0);
    check("rst_carry", 32'(CARRY), 32'd0);
    @(negedge CLOCK_50);
    RESET = 1'b0;

    // Digit encodings: every nibble value appears once
    digit_vals = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    foreach (digit_vals[i]) begin
      do_op(OP_LOAD, digit_vals[i]);
      check($sformatf("load_hex_%02h", digit_vals[i]), 32'(HEX), 32'(hex_ref(digit_vals[i])));
    end

    // Basic add
    do_op(OP_LOAD, 8'h23);
    do_op(OP_ADD,  8'h05);
    check("add_hex",   32'(HEX),   32'({7'b0100100, 7'b0000000}));
    check("add_carry", 32'(CARRY), 32'd0);

    // Add overflow
    do_op(OP_LOAD, 8'hFF);
    do_op(OP_ADD,  8'h01);
`ifdef SATURATE_EN
    exp_acc = 8'hFF;
`else
    exp_acc = 8'h00;
`endif
    check("addov_hex",   32'(HEX),   32'(hex_ref(exp_acc)));
    check("addov_carry", 32'(CARRY), 32'd1);

    // ENTER low: hold for a few cycles
    repeat (3) @(negedge CLOCK_50);
    check("hold_hex",   32'(HEX),   32'(hex_ref(exp_acc)));
    check("hold_carry", 32'(CARRY), 32'd1);

    // LOAD clears carry
    do_op(OP_LOAD, 8'h5A);
    check("load_carry", 32'(CARRY), 32'd0);
    check("load_hex",   32'(HEX),   32'(hex_ref(8'h5A)));

    // Mid-cycle asynchronous reset with carry set
    do_op(OP_ADD, 8'hC0);
    check("pre_rst_carry", 32'(CARRY), 32'd1);
    #3 RESET = 1'b1;
    #1;
    check("arst_hex",   32'(HEX),   32'({7'b1000000, 7'b1000000}));
    check("arst_busy",  32'(BUSY),  32'd0);
    check("arst_carry", 32'(CARRY), 32'd0);
    @(negedge CLOCK_50);
    RESET = 1'b0;

    // Subtract with borrow
    do_op(OP_LOAD, 8'h03);
    do_op(OP_SUB,  8'h05);
`ifdef SATURATE_EN
    exp_acc = 8'h00;
`else
    exp_acc = 8'hFE;
`endif
    check("sub_hex",   32'(HEX),   32'(hex_ref(exp_acc)));
    check("sub_carry", 32'(CARRY), 32'd1);

    // Subtract equal: no borrow
    do_op(OP_LOAD, 8'h05);
    do_op(OP_SUB,  8'h05);
    check("subeq_hex",   32'(HEX),   32'(hex_ref(8'h00)));
    check("subeq_carry", 32'(CARRY), 32'd0);

    // Multiply 0x0C * 0x0D with an ADD pulsed mid-way
    do_op(OP_LOAD, 8'h0C);
    do_op(OP_MUL,  8'h0D);
    busy_cycles = 0;
    while (BUSY && busy_cycles < 20) begin
      busy_cycles++;
      check($sformatf("mul_acc_held_%0d", busy_cycles), 32'(HEX), 32'(hex_ref(8'h0C)));
      if (busy_cycles == 3) begin
        ENTER = 1'b1; OP = OP_ADD; SW = 8'h01;
      end else begin
        ENTER = 1'b0; SW = 8'hA5; OP = OP_LOAD;
      end
      @(negedge CLOCK_50);
    end
    ENTER = 1'b0;
    check("mul_busy_cycles", 32'(busy_cycles), 32'd8);
    check("mul_hex",   32'(HEX),   32'(hex_ref(8'h9C)));
    check("mul_carry", 32'(CARRY), 32'd0);
    repeat (2) @(negedge CLOCK_50);
    check("mul_no_queue", 32'(HEX), 32'(hex_ref(8'h9C)));

    // Multiply overflow 0x10 * 0x10 = 0x100
    do_op(OP_LOAD, 8'h10);
    do_op(OP_MUL,  8'h10);
    check("mulov_busy", 32'(BUSY), 32'd1);
    wait_idle("mulov");
`ifdef SATURATE_EN
    exp_acc = 8'hFF;
`else
    exp_acc = 8'h00;
`endif
    check("mulov_hex",   32'(HEX),   32'(hex_ref(exp_acc)));
    check("mulov_carry", 32'(CARRY), 32'd1);

    // Multiply 0xFF * 0xFF = 0xFE01
    do_op(OP_LOAD, 8'hFF);
    do_op(OP_MUL,  8'hFF);
    wait_idle("mulff");
`ifdef SATURATE_EN
    exp_acc = 8'hFF;
`else
    exp_acc = 8'h01;
`endif
    check("mulff_hex",   32'(HEX),   32'(hex_ref(exp_acc)));
    check("mulff_carry", 32'(CARRY), 32'd1);

    // Reset during multiply
    do_op(OP_LOAD, 8'h07);
    do_op(OP_MUL,  8'h07);
    repeat (3) @(negedge CLOCK_50);
    check("rmul_busy_before", 32'(BUSY), 32'd1);
    #3 RESET = 1'b1;
    #1;
    check("rmul_hex",  32'(HEX),  32'(hex_ref(8'h00)));
    check("rmul_busy", 32'(BUSY), 32'd0);
    @(negedge CLOCK_50);
    RESET = 1'b0;
    repeat (10) @(negedge CLOCK_50);
    check("rmul_no_partial", 32'(HEX),  32'(hex_ref(8'h00)));
    check("rmul_idle",       32'(BUSY), 32'd0);
    do_op(OP_ADD, 8'h01);
    check("rmul_add_hex",   32'(HEX),   32'(hex_ref(8'h01)));
    check("rmul_add_carry", 32'(CARRY), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
